// File: rtl/cell_sweep_pkg.sv
// Shared definitions for the cell-array page sweeper: FSM state encoding,
// MISR constants and the MISR next-state function.
package cell_sweep_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRIVE   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_EMIT    = 3'd4,
        ST_FINISH  = 3'd5
    } state_t;

    localparam logic [15:0] MISR_POLY = 16'h1021;
    localparam logic [15:0] MISR_SEED = 16'hFFFF;
    localparam int          VEC_COUNT = 64;
    localparam logic [5:0]  LAST_VEC  = 6'(VEC_COUNT - 1);

    // One MISR step: shift left, fold in the polynomial on carry-out,
    // then XOR the captured byte into the low half.
    function automatic logic [15:0] misr_next(input logic [15:0] cur,
                                              input logic [7:0]  din);
        logic [15:0] shifted;
        shifted   = {cur[14:0], 1'b0} ^ (cur[15] ? MISR_POLY : 16'h0000);
        misr_next = shifted ^ {8'h00, din};
    endfunction

endpackage

// File: rtl/cell_sweep_misr.sv
// 16-bit multiple-input signature register. Seed takes priority over
// capture so a page reseed can never be merged with a stray capture.
module cell_sweep_misr
    import cell_sweep_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        seed,
    input  logic        capture,
    input  logic [7:0]  din,
    output logic [15:0] sig
);

    logic [15:0] r_sig;

    // Signature register: reseed on request, otherwise fold in one byte per capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sig <= MISR_SEED;
        end else if (seed) begin
            r_sig <= MISR_SEED;
        end else if (capture) begin
            r_sig <= misr_next(r_sig, din);
        end
    end

    assign sig = r_sig;

endmodule

// File: rtl/cell_sweep_seq.sv
// Page sweeper: walks every 6-bit cell vector over a range of pages, lets the
// array settle, compresses its outputs into a MISR and hands each page's
// signature to a consumer with a valid/ready handshake.
module cell_sweep_seq
    import cell_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int PAGE_FIRST    = 0,
    parameter int PAGE_LAST     = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  dut_out,
    input  logic        sig_ready,
    output logic [3:0]  page,
    output logic [5:0]  cell_in,
    output logic [15:0] sig,
    output logic [3:0]  sig_page,
    output logic        sig_valid,
    output logic        busy,
    output logic        done
);

    // Reject parameter sets the sweeper cannot honour.
    generate
        if (PAGE_LAST < PAGE_FIRST) begin : g_bad_page_range
            $error("cell_sweep_seq: PAGE_LAST must not be below PAGE_FIRST");
        end
        if (PAGE_FIRST < 0 || PAGE_LAST > 15) begin : g_bad_page_width
            $error("cell_sweep_seq: pages must fit in 4 bits");
        end
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
            $error("cell_sweep_seq: SETTLE_CYCLES must be within 1..15");
        end
    endgenerate

    localparam logic [3:0] P_FIRST     = 4'(PAGE_FIRST);
    localparam logic [3:0] P_LAST      = 4'(PAGE_LAST);
    // SETTLE lasts SETTLE_CYCLES-1 cycles; the counter counts down to zero.
    localparam logic [3:0] SETTLE_LOAD = 4'((SETTLE_CYCLES >= 2) ? (SETTLE_CYCLES - 2) : 0);

    state_t      r_state;
    logic [3:0]  r_page;
    logic [5:0]  r_cell_in;
    logic [3:0]  r_settle_cnt;
    logic [3:0]  r_sig_page;
    logic        r_sig_valid;
    logic        r_busy;
    logic        r_done;

    logic        w_seed;
    logic        w_capture;
    logic        w_abort_hit;
    logic [15:0] w_sig;

    // Abort only matters while a sweep is active; in IDLE start wins.
    assign w_abort_hit = abort && (r_state != ST_IDLE);

    // MISR reseeds at sweep start and when a non-final page is accepted.
    assign w_seed    = ((r_state == ST_IDLE) && start) ||
                       ((r_state == ST_EMIT) && !abort && sig_ready && (r_page < P_LAST));
    assign w_capture = (r_state == ST_CAPTURE) && !abort;

    cell_sweep_misr u_misr (
        .clk     (clk),
        .rst     (rst),
        .seed    (w_seed),
        .capture (w_capture),
        .din     (dut_out),
        .sig     (w_sig)
    );

    // Sweep controller: state plus all registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_page       <= 4'd0;
            r_cell_in    <= 6'd0;
            r_settle_cnt <= 4'd0;
            r_sig_page   <= 4'd0;
            r_sig_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_abort_hit) begin
                r_state     <= ST_IDLE;
                r_busy      <= 1'b0;
                r_sig_valid <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            r_page    <= P_FIRST;
                            r_cell_in <= 6'd0;
                            r_busy    <= 1'b1;
                            r_state   <= ST_DRIVE;
                        end
                    end
                    ST_DRIVE: begin
                        if (SETTLE_CYCLES == 1) begin
                            r_state <= ST_CAPTURE;
                        end else begin
                            r_settle_cnt <= SETTLE_LOAD;
                            r_state      <= ST_SETTLE;
                        end
                    end
                    ST_SETTLE: begin
                        if (r_settle_cnt == 4'd0) begin
                            r_state <= ST_CAPTURE;
                        end else begin
                            r_settle_cnt <= r_settle_cnt - 4'd1;
                        end
                    end
                    ST_CAPTURE: begin
                        if (r_cell_in == LAST_VEC) begin
                            r_cell_in   <= 6'd0;
                            r_sig_page  <= r_page;
                            r_sig_valid <= 1'b1;
                            r_state     <= ST_EMIT;
                        end else begin
                            r_cell_in <= r_cell_in + 6'd1;
                            r_state   <= ST_DRIVE;
                        end
                    end
                    ST_EMIT: begin
                        if (sig_ready) begin
                            r_sig_valid <= 1'b0;
                            if (r_page < P_LAST) begin
                                r_page  <= r_page + 4'd1;
                                r_state <= ST_DRIVE;
                            end else begin
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= ST_FINISH;
                            end
                        end
                    end
                    ST_FINISH: begin
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign page      = r_page;
    assign cell_in   = r_cell_in;
    assign sig       = w_sig;
    assign sig_page  = r_sig_page;
    assign sig_valid = r_sig_valid;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_cell_sweep_seq.sv
// Bench for cell_sweep_seq: a random per-page cell-array response table feeds
// dut_out, and page signatures are predicted by folding that table through
// the MISR rule arithmetically.
module tb_cell_sweep_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [7:0]  dut_out;
    logic        sig_ready;
    logic [3:0]  page;
    logic [5:0]  cell_in;
    logic [15:0] sig;
    logic [3:0]  sig_page;
    logic        sig_valid;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    // Emulated cell array: response byte per (page, cell vector).
    logic [7:0] tbl [0:15][0:63];

    assign dut_out = tbl[page][cell_in];

    always #5 clk = ~clk;

    cell_sweep_seq #(
        .SETTLE_CYCLES (2),
        .PAGE_FIRST    (0),
        .PAGE_LAST     (15)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .dut_out   (dut_out),
        .sig_ready (sig_ready),
        .page      (page),
        .cell_in   (cell_in),
        .sig       (sig),
        .sig_page  (sig_page),
        .sig_valid (sig_valid),
        .busy      (busy),
        .done      (done)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Expected signature of page p: seed, then fold each of the 64 bytes.
    function automatic logic [15:0] ref_sig(input int p);
        int s;
        s = 32'hFFFF;
        for (int c = 0; c < 64; c++) begin
            s = ((s * 2) % 65536) ^ ((s >= 32768) ? 32'h1021 : 32'h0) ^ int'(tbl[p][c]);
        end
        return 16'(s);
    endfunction

    task automatic fill_table(input bit zero);
        for (int p = 0; p < 16; p++)
            for (int c = 0; c < 64; c++)
                tbl[p][c] = zero ? 8'h00 : 8'($urandom);
    endtask

    // Leaves the caller at the negedge of the first DRIVE cycle.
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_page"},      32'(page),      32'h0);
        check_val({tag, "_cell_in"},   32'(cell_in),   32'h0);
        check_val({tag, "_sig"},       32'(sig),       32'hFFFF);
        check_val({tag, "_sig_page"},  32'(sig_page),  32'h0);
        check_val({tag, "_sig_valid"}, 32'(sig_valid), 32'h0);
        check_val({tag, "_busy"},      32'(busy),      32'h0);
        check_val({tag, "_done"},      32'(done),      32'h0);
    endtask

    bit          found;
    bit          seen1;
    bit          fin;
    int          lat;
    int          exp_page;
    int          done_cnt;
    int          bad_cnt;
    logic [15:0] h_sig;
    logic [3:0]  h_sig_page;

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        sig_ready = 1'b0;
        fill_table(1'b1);

        // Reset acts before any clock edge.
        #1 rst = 1'b1;
        #1;
        check_reset_outputs("rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Zero stream: first capture value and emit latency.
        pulse_start();
        check_val("p1_busy",    32'(busy),    32'h1);
        check_val("p1_page",    32'(page),    32'h0);
        check_val("p1_cell_in", 32'(cell_in), 32'h0);
        check_val("p1_sig",     32'(sig),     32'hFFFF);
        found = 1'b0;
        seen1 = 1'b0;
        lat   = 0;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (cell_in == 6'd1 && !seen1) begin
                seen1 = 1'b1;
                check_val("p1_first_capture", 32'(sig), 32'hEFDF);
            end
            if (sig_valid) begin
                found = 1'b1;
                lat   = i;
                break;
            end
        end
        check_val("p1_emit_found",   32'(found), 32'h1);
        check_val("p1_emit_latency", 32'(lat),   32'd192);
        check_val("p1_emit_sig",     32'(sig),   32'(ref_sig(0)));
        check_val("p1_emit_page",    32'(sig_page), 32'h0);

        // Backpressure: everything must hold while sig_ready stays low.
        h_sig      = sig;
        h_sig_page = sig_page;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_val($sformatf("p1_hold%0d_sig", i),      32'(sig),       32'(h_sig));
            check_val($sformatf("p1_hold%0d_sig_page", i), 32'(sig_page),  32'(h_sig_page));
            check_val($sformatf("p1_hold%0d_valid", i),    32'(sig_valid), 32'h1);
            check_val($sformatf("p1_hold%0d_page", i),     32'(page),      32'h0);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_val("p1_abort_busy",  32'(busy),      32'h0);
        check_val("p1_abort_valid", 32'(sig_valid), 32'h0);
        check_val("p1_abort_done",  32'(done),      32'h0);

        // Full random sweep with random backpressure and stray start pulses.
        fill_table(1'b0);
        sig_ready = 1'b0;
        pulse_start();
        exp_page = 0;
        done_cnt = 0;
        fin      = 1'b0;
        for (int i = 0; i < 20000 && !fin; i++) begin
            if (done) begin
                done_cnt++;
                check_val("p2_done_pages", 32'(exp_page), 32'd16);
                check_val("p2_done_busy",  32'(busy),     32'h0);
                fin = 1'b1;
            end else begin
                if (sig_valid)
                    check_val("p2_valid_busy", 32'(busy), 32'h1);
                sig_ready = ($urandom_range(0, 3) != 0);
                if (sig_valid && sig_ready) begin
                    check_val($sformatf("p2_sig_page%0d", exp_page), 32'(sig_page), 32'(exp_page));
                    check_val($sformatf("p2_sig%0d", exp_page), 32'(sig), 32'(ref_sig(exp_page)));
                    exp_page++;
                end
                start = (busy && exp_page < 16) ? ($urandom_range(0, 7) == 0) : 1'b0;
                @(negedge clk);
            end
        end
        start     = 1'b0;
        sig_ready = 1'b0;
        check_val("p2_finished",  32'(fin),      32'h1);
        check_val("p2_done_cnt",  32'(done_cnt), 32'h1);
        check_val("p2_sig_count", 32'(exp_page), 32'd16);
        @(negedge clk);
        check_val("p2_done_pulse_end", 32'(done), 32'h0);
        check_val("p2_idle_busy",      32'(busy), 32'h0);

        // Abort at page 3, vector 20.
        sig_ready = 1'b1;
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (page == 4'd3 && cell_in == 6'd20) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_val("p3_reach_p3c20", 32'(found), 32'h1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_val("p3_abort_busy",  32'(busy),      32'h0);
        check_val("p3_abort_valid", 32'(sig_valid), 32'h0);
        check_val("p3_abort_done",  32'(done),      32'h0);
        bad_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sig_valid || done || busy) bad_cnt++;
        end
        check_val("p3_quiet_after_abort", 32'(bad_cnt), 32'h0);
        pulse_start();
        check_val("p3_restart_page",    32'(page),    32'h0);
        check_val("p3_restart_cell_in", 32'(cell_in), 32'h0);
        check_val("p3_restart_busy",    32'(busy),    32'h1);
        check_val("p3_restart_sig",     32'(sig),     32'hFFFF);

        // Asynchronous reset in the middle of a SETTLE cycle.
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (cell_in == 6'd5) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_val("p4_reach_c5", 32'(found), 32'h1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("p4_async_rst");
        @(negedge clk);
        rst       = 1'b0;
        sig_ready = 1'b0;
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (sig_valid) begin
                found = 1'b1;
                break;
            end
        end
        check_val("p4_emit_found", 32'(found),    32'h1);
        check_val("p4_emit_page",  32'(sig_page), 32'h0);
        check_val("p4_emit_sig",   32'(sig),      32'(ref_sig(0)));
        sig_ready = 1'b1;
        @(negedge clk);
        sig_ready = 1'b0;
        check_val("p4_next_page",  32'(page),      32'h1);
        check_val("p4_next_valid", 32'(sig_valid), 32'h0);
        check_val("p4_reseed",     32'(sig),       32'hFFFF);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
